// File: rtl/maestro_hci_width_arbiter.sv
// Width-mode arbiter sharing one HWPE interconnect between a wide and a narrow initiator.
// Drains outstanding reads before every width switch so r_valid never crosses lane maps.
module maestro_hci_width_arbiter #(
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter bit          RESET_WIDE      = 1'b1,
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned BW = $clog2(MAX_BURST + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          wide_req_i,
    input  logic          narrow_req_i,
    output logic          wide_gnt_o,
    output logic          narrow_gnt_o,
    output logic          wide_rvalid_o,
    output logic          narrow_rvalid_o,
    output logic          ic_req_o,
    input  logic          ic_gnt_i,
    input  logic          ic_rvalid_i,
    output logic          sel_o,
    output logic          busy_o,
    output logic [OW-1:0] outstanding_o
);

    typedef enum logic [1:0] {
        S_WIDE,
        S_NARROW,
        S_DRAIN_TO_WIDE,
        S_DRAIN_TO_NARROW
    } state_e;

    localparam state_e RESET_STATE = RESET_WIDE ? S_WIDE : S_NARROW;

    state_e         r_state;
    state_e         w_state_next;
    logic           r_sel;
    logic           r_owner;
    logic [OW-1:0]  r_out;
    logic [OW-1:0]  w_out_next;
    logic [BW-1:0]  r_burst;
    logic           w_sw;
    logic           w_req;
    logic           w_hs;
    logic           w_rv;
    logic           w_full;
    logic           w_bsat;
    logic           w_enter;

    assign w_full = (r_out == OW'(MAX_OUTSTANDING));
    assign w_bsat = (r_burst == BW'(MAX_BURST));

    always_comb begin
        w_sw  = 1'b0;
        w_req = 1'b0;
        unique case (r_state)
            S_WIDE: begin
                w_sw  = narrow_req_i & (~wide_req_i | w_bsat);
                w_req = wide_req_i & ~w_sw & ~w_full;
            end
            S_NARROW: begin
                w_sw  = wide_req_i & (~narrow_req_i | w_bsat);
                w_req = narrow_req_i & ~w_sw & ~w_full;
            end
            default: ;
        endcase
    end

    assign w_hs = w_req & ic_gnt_i;
    // r_valid with nothing in flight is dropped and never underflows the counter
    assign w_rv = ic_rvalid_i & (r_out != '0);

    always_comb begin
        w_out_next = r_out;
        unique case ({w_hs, w_rv})
            2'b10:   w_out_next = r_out + OW'(1);
            2'b01:   w_out_next = r_out - OW'(1);
            default: w_out_next = r_out;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_WIDE:            if (w_sw) w_state_next = S_DRAIN_TO_NARROW;
            S_NARROW:          if (w_sw) w_state_next = S_DRAIN_TO_WIDE;
            S_DRAIN_TO_WIDE:   if (w_out_next == '0) w_state_next = S_WIDE;
            S_DRAIN_TO_NARROW: if (w_out_next == '0) w_state_next = S_NARROW;
            default:           w_state_next = RESET_STATE;
        endcase
    end

    assign w_enter = busy_o & (w_state_next != r_state);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RESET_STATE;
            r_sel   <= RESET_WIDE;
            r_owner <= RESET_WIDE;
            r_out   <= '0;
            r_burst <= '0;
        end else if (clear_i) begin
            r_state <= RESET_STATE;
            r_sel   <= RESET_WIDE;
            r_owner <= RESET_WIDE;
            r_out   <= '0;
            r_burst <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            if (w_hs) r_owner <= r_sel;
            if (w_enter) begin
                r_burst <= '0;
                r_sel   <= (w_state_next == S_WIDE);
            end else if (w_hs && !w_bsat) begin
                r_burst <= r_burst + BW'(1);
            end
        end
    end

    assign ic_req_o        = w_req;
    assign wide_gnt_o      = (r_state == S_WIDE) & w_hs;
    assign narrow_gnt_o    = (r_state == S_NARROW) & w_hs;
    assign wide_rvalid_o   = w_rv & r_owner;
    assign narrow_rvalid_o = w_rv & ~r_owner;
    assign sel_o           = r_sel;
    assign busy_o          = (r_state == S_DRAIN_TO_WIDE) |
                             (r_state == S_DRAIN_TO_NARROW);
    assign outstanding_o   = r_out;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i) begin
            assert (!(ic_rvalid_i && r_out == '0))
            else $warning("stray r_valid with nothing outstanding ignored");
        end
    end
`endif

endmodule
